// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key expansion: one new schedule word per clock through a shared SubWord,
// with the 11 round keys held locally and served on a one-cycle registered read port.
module key_schedule_ctrl #(
    parameter int Nk = 4,
    parameter int Nr = 10,
    parameter int Nb = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] i_key_in,
    input  logic         i_key_valid,
    output logic         o_key_ready,
    output logic         o_busy,
    output logic         o_rk_ready,
    output logic [3:0]   o_rk_avail,
    input  logic         i_rk_rd_en,
    input  logic [3:0]   i_rk_rd_idx,
    output logic [127:0] o_rk_out,
    output logic         o_rk_out_valid
);

    generate
        if ((Nk != 4) || (Nr != 10) || (Nb != 4)) begin : g_badParam
            $error("key_schedule_ctrl supports only AES-128 (Nk=4, Nr=10, Nb=4)");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [5:0]     r_cnt;
    logic [7:0]     r_rcon;
    logic [127:0]   r_win;
    logic [3:0]     r_avail;
    logic [127:0]   r_rkOut;
    logic           r_rkOutValid;
    logic [127:0]   r_rk [0:10];

    logic           w_accept;
    logic           w_expand;
    logic [31:0]    w_prev4;
    logic [31:0]    w_prev1;
    logic [31:0]    w_rot;
    logic [31:0]    w_sub;
    logic [31:0]    w_newWord;
    logic [6:0]     w_bitLo;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, which also maps 0 to 0) followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gfMul(x, x);
        inv = sq;
        for (int k = 0; k < 6; k++) begin
            sq  = gfMul(sq, sq);
            inv = gfMul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign w_accept  = i_key_valid && (r_state != S_EXPAND);
    assign w_expand  = (r_state == S_EXPAND);
    assign w_prev4   = r_win[127:96];
    assign w_prev1   = r_win[31:0];
    assign w_rot     = {w_prev1[23:0], w_prev1[31:24]};
    assign w_sub     = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
    assign w_newWord = (r_cnt[1:0] == 2'd0) ? (w_prev4 ^ w_sub ^ {r_rcon, 24'h0})
                                            : (w_prev4 ^ w_prev1);
    assign w_bitLo   = {~r_cnt[1:0], 5'b00000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        o_key_ready = 1'b1;
        o_busy      = 1'b0;
        o_rk_ready  = 1'b0;
        case (r_state)
            S_IDLE, S_READY: begin
                o_rk_ready = (r_state == S_READY);
                if (w_accept) w_nextState = S_EXPAND;
            end
            S_EXPAND: begin
                o_key_ready = 1'b0;
                o_busy      = 1'b1;
                if (r_cnt == 6'd43) w_nextState = S_READY;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // r_win is a sliding window of w[i-4..i-1], so the round logic never indexes the key store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 6'd0;
            r_rcon       <= 8'h01;
            r_win        <= 128'h0;
            r_avail      <= 4'd0;
            r_rkOut      <= 128'h0;
            r_rkOutValid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= 6'd4;
                r_rcon  <= 8'h01;
                r_win   <= i_key_in;
                r_avail <= 4'd1;
            end else if (w_expand) begin
                r_cnt <= r_cnt + 6'd1;
                r_win <= {r_win[95:0], w_newWord};
                if (r_cnt[1:0] == 2'd0) r_rcon <= xtime(r_rcon);
                if (r_cnt[1:0] == 2'd3) r_avail <= r_avail + 4'd1;
            end
            r_rkOutValid <= i_rk_rd_en;
            if (i_rk_rd_en) begin
                r_rkOut <= (i_rk_rd_idx <= 4'd10) ? r_rk[i_rk_rd_idx] : 128'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rk[0] <= i_key_in;
        end else if (w_expand) begin
            r_rk[r_cnt[5:2]][w_bitLo +: 32] <= w_newWord;
        end
    end

    assign o_rk_avail     = r_avail;
    assign o_rk_out       = r_rkOut;
    assign o_rk_out_valid = r_rkOutValid;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl using the FIPS-197 AES-128 expansion vectors.
module tb_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rstN;
    logic [127:0] keyIn;
    logic         keyValid;
    logic         keyReady;
    logic         busy;
    logic         rkReady;
    logic [3:0]   rkAvail;
    logic         rdEn;
    logic [3:0]   rdIdx;
    logic [127:0] rkOut;
    logic         rkOutValid;

    int checks = 0;
    int failures = 0;

    logic [127:0] ref1 [0:10];
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KZ_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_schedule_ctrl dut (
        .clk           (clk),
        .rst_n         (rstN),
        .i_key_in      (keyIn),
        .i_key_valid   (keyValid),
        .o_key_ready   (keyReady),
        .o_busy        (busy),
        .o_rk_ready    (rkReady),
        .o_rk_avail    (rkAvail),
        .i_rk_rd_en    (rdEn),
        .i_rk_rd_idx   (rdIdx),
        .o_rk_out      (rkOut),
        .o_rk_out_valid(rkOutValid)
    );

    always #5 clk = ~clk;

    // Consumers must never read a round key that is not yet complete during expansion.
    always @(posedge clk) begin
        if (rstN && busy && rdEn && (rdIdx >= rkAvail)) begin
            failures++;
            $display("[TB] FAIL rd_gate idx=%0d avail=%0d (need idx < avail)", rdIdx, rkAvail);
        end
    end

    task automatic start_key(input logic [127:0] k);
        keyIn = k;
        keyValid = 1'b1;
        @(posedge clk); #1;
        keyValid = 1'b0;
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] d, output logic v);
        rdEn = 1'b1;
        rdIdx = idx;
        @(posedge clk); #1;
        rdEn = 1'b0;
        d = rkOut;
        v = rkOutValid;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!rkReady && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!rkReady) begin
            checks++; failures++;
            $display("[TB] FAIL wait_ready timeout got rk_ready=%b exp=1", rkReady);
        end
    endtask

    task automatic test_reset;
        rstN = 1'b0; keyIn = '0; keyValid = 1'b0; rdEn = 1'b0; rdIdx = '0;
        #12;
        checks++; if (keyReady !== 1'b1) begin failures++; $display("[TB] FAIL rst_key_ready got=%b exp=1", keyReady); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (rkReady !== 1'b0) begin failures++; $display("[TB] FAIL rst_rk_ready got=%b exp=0", rkReady); end
        checks++; if (rkAvail !== 4'd0) begin failures++; $display("[TB] FAIL rst_avail got=%0d exp=0", rkAvail); end
        checks++; if (rkOut !== 128'h0) begin failures++; $display("[TB] FAIL rst_rk_out got=%h exp=0", rkOut); end
        checks++; if (rkOutValid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%b exp=0", rkOutValid); end
        #3 rstN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vector1;
        int cyc;
        logic [127:0] d;
        logic v;
        start_key(K1);
        wait_ready(cyc);
        checks++; if (cyc != 40) begin failures++; $display("[TB] FAIL v1_latency got=%0d exp=40", cyc); end
        read_rk(4'd1, d, v);
        checks++; if (d !== ref1[1] || v !== 1'b1) begin failures++; $display("[TB] FAIL v1_rk1 got=%h/%b exp=%h/1", d, v, ref1[1]); end
        read_rk(4'd10, d, v);
        checks++; if (d !== ref1[10] || v !== 1'b1) begin failures++; $display("[TB] FAIL v1_rk10 got=%h/%b exp=%h/1", d, v, ref1[10]); end
    endtask

    task automatic test_vectors2;
        int cyc;
        logic [127:0] d;
        logic v;
        start_key(K2);
        wait_ready(cyc);
        read_rk(4'd10, d, v);
        checks++; if (d !== K2_RK10) begin failures++; $display("[TB] FAIL v2_rk10 got=%h exp=%h", d, K2_RK10); end
        read_rk(4'd0, d, v);
        checks++; if (d !== K2) begin failures++; $display("[TB] FAIL v2_rk0 got=%h exp=%h", d, K2); end
        start_key(128'h0);
        wait_ready(cyc);
        read_rk(4'd10, d, v);
        checks++; if (d !== KZ_RK10) begin failures++; $display("[TB] FAIL vz_rk10 got=%h exp=%h", d, KZ_RK10); end
        read_rk(4'd0, d, v);
        checks++; if (d !== 128'h0) begin failures++; $display("[TB] FAIL vz_rk0 got=%h exp=0", d); end
    endtask

    task automatic test_hold_valid;
        int cyc;
        logic [127:0] d;
        logic v;
        keyIn = K1;
        keyValid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 40; k++) begin
            checks++; if (keyReady !== 1'b0) begin failures++; $display("[TB] FAIL hold_key_ready k=%0d got=%b exp=0", k, keyReady); end
            keyIn = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        checks++; if (rkReady !== 1'b1 || keyReady !== 1'b1) begin failures++; $display("[TB] FAIL hold_done got=%b/%b exp=1/1", rkReady, keyReady); end
        keyIn = 128'h0;
        rdEn = 1'b1;
        rdIdx = 4'd10;
        @(posedge clk); #1;
        rdEn = 1'b0;
        keyValid = 1'b0;
        checks++; if (rkOut !== ref1[10]) begin failures++; $display("[TB] FAIL hold_first_rk10 got=%h exp=%h", rkOut, ref1[10]); end
        checks++; if (rkReady !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL hold_second_accept got=%b/%b exp=0/1", rkReady, busy); end
        wait_ready(cyc);
        read_rk(4'd10, d, v);
        checks++; if (d !== KZ_RK10) begin failures++; $display("[TB] FAIL hold_second_rk10 got=%h exp=%h", d, KZ_RK10); end
    endtask

    task automatic test_avail_poll;
        start_key(K1);
        checks++; if (busy !== 1'b1 || keyReady !== 1'b0) begin failures++; $display("[TB] FAIL poll_busy got=%b/%b exp=1/0", busy, keyReady); end
        for (int k = 0; k <= 40; k++) begin
            checks++; if (rkAvail !== 4'(1 + k / 4)) begin failures++; $display("[TB] FAIL poll_avail k=%0d got=%0d exp=%0d", k, rkAvail, 1 + k / 4); end
            if (k < 40) begin
                rdEn = 1'b1;
                rdIdx = 4'(k / 4);
                @(posedge clk); #1;
                rdEn = 1'b0;
                checks++; if (rkOut !== ref1[k / 4] || rkOutValid !== 1'b1) begin failures++; $display("[TB] FAIL poll_rk k=%0d got=%h exp=%h", k, rkOut, ref1[k / 4]); end
            end
        end
        checks++; if (rkReady !== 1'b1) begin failures++; $display("[TB] FAIL poll_rk_ready got=%b exp=1", rkReady); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        logic [127:0] d;
        logic v;
        start_key(K1);
        repeat (16) begin @(posedge clk); #1; end
        rdEn = 1'b1;
        rdIdx = 4'd0;
        @(posedge clk); #1;
        rdEn = 1'b0;
        rstN = 1'b0;
        #1;
        checks++; if (keyReady !== 1'b1 || busy !== 1'b0 || rkReady !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_flags got=%b%b%b exp=100", keyReady, busy, rkReady); end
        checks++; if (rkAvail !== 4'd0) begin failures++; $display("[TB] FAIL mid_rst_avail got=%0d exp=0", rkAvail); end
        checks++; if (rkOut !== 128'h0 || rkOutValid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_out got=%h/%b exp=0/0", rkOut, rkOutValid); end
        #2 rstN = 1'b1;
        @(posedge clk); #1;
        start_key(K1);
        wait_ready(cyc);
        checks++; if (cyc != 40) begin failures++; $display("[TB] FAIL mid_latency got=%0d exp=40", cyc); end
        read_rk(4'd1, d, v);
        checks++; if (d !== ref1[1]) begin failures++; $display("[TB] FAIL mid_rk1 got=%h exp=%h", d, ref1[1]); end
        read_rk(4'd10, d, v);
        checks++; if (d !== ref1[10]) begin failures++; $display("[TB] FAIL mid_rk10 got=%h exp=%h", d, ref1[10]); end
    endtask

    task automatic test_read_port;
        logic [127:0] d;
        logic v;
        read_rk(4'd15, d, v);
        checks++; if (d !== 128'h0 || v !== 1'b1) begin failures++; $display("[TB] FAIL rd_oob got=%h/%b exp=0/1", d, v); end
        rdEn = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            rdIdx = 4'(j);
            @(posedge clk); #1;
            checks++; if (rkOut !== ref1[j] || rkOutValid !== 1'b1) begin failures++; $display("[TB] FAIL rd_b2b j=%0d got=%h/%b exp=%h/1", j, rkOut, rkOutValid, ref1[j]); end
        end
        rdEn = 1'b0;
        @(posedge clk); #1;
        checks++; if (rkOutValid !== 1'b0 || rkOut !== ref1[10]) begin failures++; $display("[TB] FAIL rd_idle got=%h/%b exp=%h/0", rkOut, rkOutValid, ref1[10]); end
    endtask

    initial begin
        ref1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ref1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        ref1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        ref1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        ref1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        ref1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        ref1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        ref1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        ref1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        ref1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        ref1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        test_reset();
        test_vector1();
        test_vectors2();
        test_hold_valid();
        test_avail_poll();
        test_reset_mid();
        test_read_port();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
